mem_access_ctrl: RTL

//  Clocked load/store front-end for the processor's data memory. It accepts one read or write request at a time from
//  the execute stage over a valid/ready handshake and drives the memory block's enable/control/data pins. It runs a

---
 rtl/mem_access_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store front-end for the data memory: valid/ready request in, four-phase
// enable/done handshake with range check and timeout, valid/ready response out.
module mem_access_ctrl #(
  parameter int SIZE           = 32,
  parameter int MAX_RANGE      = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SIZE*2-1:0] req_addr_a,
  input  logic [SIZE*2-1:0] req_addr_b,
  input  logic [SIZE*2-1:0] req_wdata,
  output logic              mem_enable,
  output logic              mem_control,
  output logic [SIZE*2-1:0] mem_data1,
  output logic [SIZE*2-1:0] mem_data2,
  input  logic [SIZE*2-1:0] mem_out1,
  input  logic [SIZE*2-1:0] mem_out2,
  input  logic              mem_done,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [SIZE-1:0]   resp_data_a,
  output logic [SIZE-1:0]   resp_data_b,
  output logic              resp_err
);
  localparam int AW = SIZE * 2;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] LIM = AW'(MAX_RANGE);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RELEASE, RESP} state_t;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [AW-1:0] wdata;
  } req_t;

  state_t        state, state_n;
  req_t          rq;
  logic [CW-1:0] cnt, cnt_inc;
  logic          accept, range_bad, cnt_exp, busy;
  logic          unused_hi;

  assign accept    = req_valid & req_ready;
  assign range_bad = (req_addr_a >= LIM) | (~req_write & (req_addr_b >= LIM));
  // saturating: the counter parks at TMO instead of wrapping
  assign cnt_inc   = (cnt == TMO) ? cnt : cnt + 1'b1;
  assign cnt_exp   = (cnt_inc == TMO);
  assign unused_hi = ^{mem_out1[AW-1:SIZE], mem_out2[AW-1:SIZE]};

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (accept) state_n = range_bad ? RESP : ISSUE;
      ISSUE:     state_n = WAIT_DONE;
      WAIT_DONE: if (mem_done) state_n = RELEASE;
                 else if (cnt_exp) state_n = RESP;
      RELEASE:   if (!mem_done || cnt_exp) state_n = RESP;
      RESP:      if (resp_ready) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // memory buses are live from ISSUE (setup cycle) through RELEASE
  assign busy        = (state == ISSUE) || (state == WAIT_DONE) || (state == RELEASE);
  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign mem_enable  = (state == WAIT_DONE);
  assign mem_control = busy & rq.write;
  assign mem_data1   = busy ? (rq.write ? rq.wdata  : rq.addr_a) : '0;
  assign mem_data2   = busy ? (rq.write ? rq.addr_a : rq.addr_b) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rq          <= '0;
      cnt         <= '0;
      resp_err    <= 1'b0;
      resp_data_a <= '0;
      resp_data_b <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            rq          <= '{write: req_write, addr_a: req_addr_a,
                             addr_b: req_addr_b, wdata: req_wdata};
            resp_err    <= range_bad;
            resp_data_a <= '0;
            resp_data_b <= '0;
          end
        end
        WAIT_DONE: begin
          if (mem_done) begin
            cnt <= '0;
            if (!rq.write) begin
              resp_data_a <= mem_out1[SIZE-1:0];
              resp_data_b <= mem_out2[SIZE-1:0];
            end
          end else begin
            cnt <= cnt_inc;
            if (cnt_exp) resp_err <= 1'b1;
          end
        end
        RELEASE: begin
          cnt <= cnt_inc;
          // sticky done: give up but keep any captured load data
          if (mem_done && cnt_exp) resp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
